// File: rtl/calc_pkg.sv
// Shared definitions for the arithmetic units and their display back end.
//   BIN_W_DEF / DIGITS_DEF : default binary width and BCD digit count for the
//                            binary-to-BCD converter (10^5 > 2^16-1).
//   bcd_state_t            : converter FSM states.
//   BCD_ADJ_THRESH/ADD     : double-dabble digit correction (>=5 gets +3).
package calc_pkg;

  localparam int BIN_W_DEF  = 16;
  localparam int DIGITS_DEF = 5;

  localparam int BCD_ADJ_THRESH = 5;
  localparam int BCD_ADJ_ADD    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit, purely combinational.
//   i_dig : scratch digit before the shift
//   o_dig : i_dig + 3 when i_dig >= 5, else i_dig (4-bit wrap, no carry out)
module bcd_digit_adj
  import calc_pkg::*;
(
  input  logic [3:0] i_dig,
  output logic [3:0] o_dig
);

  always_comb begin
    if (i_dig >= 4'(BCD_ADJ_THRESH))
      o_dig = i_dig + 4'(BCD_ADJ_ADD);
    else
      o_dig = i_dig;
  end

endmodule

// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock. Feeds packed BCD digits and a leading-zero blanking mask to the
// seven-segment driver.
//   clk         : system clock, rising edge
//   rst_n       : synchronous active-low reset
//   start       : request conversion of bin_in (honoured only when idle)
//   bin_in      : unsigned value to convert, captured at the accept edge
//   busy        : high through SHIFT and DONE
//   done        : one-cycle pulse when bcd_out/digit_valid update
//   bcd_out     : packed BCD, digit 0 in bits [3:0]
//   digit_valid : bit i set if digit i is displayed; bit 0 always set
module bcd_convert_seq
  import calc_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_valid
);

  localparam int CNT_W = $clog2(BIN_W);
  localparam int SCR_W = 4 * DIGITS;

  bcd_state_t          r_state;
  logic [BIN_W-1:0]    r_bin;
  logic [SCR_W-1:0]    r_scr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [SCR_W-1:0]    r_bcd;
  logic [DIGITS-1:0]   r_dv;

  logic [SCR_W-1:0]       w_adj;
  logic [SCR_W+BIN_W-1:0] w_cat_sh;
  logic [SCR_W-1:0]       w_scr_next;
  logic [BIN_W-1:0]       w_bin_next;
  logic [DIGITS-1:0]      w_dv_next;
  logic                   w_any;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_dig (r_scr[4*g +: 4]),
      .o_dig (w_adj[4*g +: 4])
    );
  end

  // Adjusted scratch and binary shift left together as one register.
  always_comb begin
    w_cat_sh   = {w_adj, r_bin} << 1;
    w_scr_next = w_cat_sh[SCR_W+BIN_W-1:BIN_W];
    w_bin_next = w_cat_sh[BIN_W-1:0];
  end

  // Blanking mask: digit i shown if it or any higher digit is nonzero.
  always_comb begin
    w_dv_next = '0;
    w_any     = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      w_any = w_any | (w_scr_next[4*(DIGITS-1-i) +: 4] != 4'd0);
      w_dv_next[DIGITS-1-i] = w_any;
    end
    w_dv_next[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_scr   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bcd   <= '0;
      r_dv    <= DIGITS'(1);
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_bin   <= bin_in;
            r_scr   <= '0;
            r_cnt   <= CNT_W'(BIN_W - 1);
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_scr <= w_scr_next;
          r_bin <= w_bin_next;
          if (r_cnt == '0) begin
            r_bcd   <= w_scr_next;
            r_dv    <= w_dv_next;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign bcd_out     = r_bcd;
  assign digit_valid = r_dv;

endmodule

// File: tb/tb_bcd_convert_seq.sv
module tb_bcd_convert_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bin_in;
  logic        busy;
  logic        done;
  logic [19:0] bcd_out;
  logic [4:0]  digit_valid;

  int total;
  int bad;

  bcd_convert_seq #(.BIN_W(16), .DIGITS(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bin_in      (bin_in),
    .busy        (busy),
    .done        (done),
    .bcd_out     (bcd_out),
    .digit_valid (digit_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] exp_bcd;
    logic [4:0]  exp_mask;
  } vec_t;

  // Reference model: decimal digits by plain division.
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_mask(input int unsigned v);
    logic [4:0] m;
    int unsigned pw;
    m = 5'b00001;
    pw = 10;
    for (int i = 1; i < 5; i++) begin
      if (v >= pw) m[i] = 1'b1;
      pw = pw * 10;
    end
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [19:0] last_bcd;

  // One isolated conversion: checks latency, busy length, single done,
  // hold of outputs during SHIFT and the final result.
  task automatic run_conv(input string name, input logic [15:0] v,
                          input logic [19:0] e_bcd, input logic [4:0] e_mask);
    int done_at, done_cnt, busy_cnt;
    logic [19:0] got_bcd;
    logic [4:0]  got_mask;
    done_at = 0; done_cnt = 0; busy_cnt = 0;
    got_bcd = '0; got_mask = '0;
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 3) bin_in = 16'($urandom);
      if (n == 5) chk({name, "_hold"}, 32'(bcd_out), 32'(last_bcd));
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at  = n;
          got_bcd  = bcd_out;
          got_mask = digit_valid;
        end
      end
    end
    chk({name, "_done_at"}, 32'(done_at), 32'd17);
    chk({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({name, "_busy_cnt"}, 32'(busy_cnt), 32'd17);
    chk({name, "_bcd"}, 32'(got_bcd), 32'(e_bcd));
    chk({name, "_mask"}, 32'(got_mask), 32'(e_mask));
    last_bcd = e_bcd;
  endtask

  vec_t vecs[$];

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; bin_in = '0;
    last_bcd = '0;

    vecs.push_back('{16'd0,     20'h00000, 5'b00001});
    vecs.push_back('{16'd65535, 20'h65535, 5'b11111});
    vecs.push_back('{16'd65025, 20'h65025, 5'b11111});
    vecs.push_back('{16'd120,   20'h00120, 5'b00111});
    vecs.push_back('{16'd1,     20'h00001, 5'b00001});
    vecs.push_back('{16'd10,    20'h00010, 5'b00011});
    vecs.push_back('{16'd59999, 20'h59999, 5'b11111});

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'h0);
    chk("rst_mask", 32'(digit_valid), 32'b00001);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      // a few idle cycles, standing in for the upstream multiplier latency
      repeat (3) @(negedge clk);
      run_conv($sformatf("vec%0d", i), vecs[i].bin, vecs[i].exp_bcd, vecs[i].exp_mask);
    end

    for (int i = 0; i < 15; i++) begin
      int unsigned v;
      v = $urandom_range(0, 65535);
      run_conv($sformatf("rnd%0d", i), 16'(v), ref_bcd(v), ref_mask(v));
    end

    // Back-to-back with start held high, including through DONE.
    begin
      int dn, first_at, second_at;
      logic [19:0] b1, b2;
      logic [4:0]  m1, m2;
      dn = 0; first_at = 0; second_at = 0;
      b1 = '0; b2 = '0; m1 = '0; m2 = '0;
      @(negedge clk);
      start = 1'b1; bin_in = 16'd1000;
      for (int n = 1; n <= 50; n++) begin
        @(negedge clk);
        if (done) begin
          dn++;
          if (dn == 1) begin
            first_at = n; b1 = bcd_out; m1 = digit_valid; bin_in = 16'd9;
          end else if (dn == 2) begin
            second_at = n; b2 = bcd_out; m2 = digit_valid; start = 1'b0;
          end
        end
      end
      start = 1'b0;
      chk("b2b_first_bcd", 32'(b1), 32'h01000);
      chk("b2b_first_mask", 32'(m1), 32'b01111);
      chk("b2b_second_bcd", 32'(b2), 32'h00009);
      chk("b2b_second_mask", 32'(m2), 32'b00001);
      chk("b2b_done_cnt", 32'(dn), 32'd2);
      chk("b2b_first_at", 32'(first_at), 32'd17);
      chk("b2b_gap_ok", 32'((second_at - first_at >= 17) && (second_at - first_at <= 18)), 32'd1);
      last_bcd = 20'h00009;
    end

    // start pulses and bin_in changes while shifting
    begin
      int dn;
      logic [19:0] b;
      dn = 0; b = '0;
      repeat (2) @(negedge clk);
      start = 1'b1; bin_in = 16'd4321;
      for (int n = 1; n <= 25; n++) begin
        @(negedge clk);
        start = (n == 5 || n == 9 || n == 10) ? 1'b1 : 1'b0;
        if (n >= 5) bin_in = 16'd7;
        if (done) begin dn++; b = bcd_out; end
      end
      start = 1'b0;
      chk("midshift_bcd", 32'(b), 32'h04321);
      chk("midshift_done_cnt", 32'(dn), 32'd1);
      last_bcd = 20'h04321;
    end

    // reset mid-conversion
    begin
      int dn;
      dn = 0;
      @(negedge clk);
      start = 1'b1; bin_in = 16'd9999;
      for (int n = 1; n <= 30; n++) begin
        @(negedge clk);
        start = 1'b0;
        if (n == 8) rst_n = 1'b0;
        if (n == 9) begin
          rst_n = 1'b1;
          chk("rstmid_busy", 32'(busy), 32'd0);
          chk("rstmid_bcd", 32'(bcd_out), 32'h0);
          chk("rstmid_mask", 32'(digit_valid), 32'b00001);
        end
        if (done) dn++;
      end
      chk("rstmid_done_cnt", 32'(dn), 32'd0);
      last_bcd = '0;
      run_conv("after_rst", 16'd42, 20'h00042, 5'b00011);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
